// File: rtl/i2c_pkg.sv
// Shared types for the I2C condition generator: command codes, FSM states and
// small per-phase lookup helpers used by the sequencer.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START   = 2'b00,
    CMD_RSTART  = 2'b01,
    CMD_STOP    = 2'b10,
    CMD_ILLEGAL = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    RS_SDA_HI,
    RS_SCL_HI,
    ST_SDA_LO,
    ST_SCL_LO,
    SP_SDA_LO,
    SP_SCL_HI,
    SP_SDA_HI
  } state_e;

  // {sda_oe, scl_oe} driven for the whole of a phase; IDLE has no levels of its own
  function automatic logic [1:0] phase_oe(state_e s);
    logic [1:0] oe;
    case (s)
      RS_SDA_HI: oe = 2'b01;
      RS_SCL_HI: oe = 2'b00;
      ST_SDA_LO: oe = 2'b10;
      ST_SCL_LO: oe = 2'b11;
      SP_SDA_LO: oe = 2'b11;
      SP_SCL_HI: oe = 2'b10;
      SP_SDA_HI: oe = 2'b00;
      default:   oe = 2'b00;
    endcase
    return oe;
  endfunction

  // Phase that follows s; IDLE marks the end of a sequence
  function automatic state_e next_phase(state_e s);
    state_e n;
    case (s)
      RS_SDA_HI: n = RS_SCL_HI;
      RS_SCL_HI: n = ST_SDA_LO;
      ST_SDA_LO: n = ST_SCL_LO;
      SP_SDA_LO: n = SP_SCL_HI;
      SP_SCL_HI: n = SP_SDA_HI;
      default:   n = IDLE;
    endcase
    return n;
  endfunction

  // Phases in which SCL is released and a slave may stretch it
  function automatic logic is_scl_release(state_e s);
    return (s == RS_SCL_HI) || (s == SP_SCL_HI);
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Phase down-counter: load sets the phase length (>= 1), each enabled cycle
// counts one, and expire flags the last enabled cycle of the phase.
module i2c_phase_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [Width-1:0] r_cnt;

  // Load wins over counting; the count parks at 1 so a frozen phase never expires
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= Width'(1);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != Width'(1))) begin
      r_cnt <= r_cnt - Width'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == Width'(1));

endmodule

// File: rtl/i2c_cond_generator.sv
// I2C START / repeated-START / STOP condition generator driving open-drain
// enables. Optional SCL clock stretching in the SCL-release phases is enabled
// by defining I2C_SCL_STRETCH_EN; otherwise scl_in is ignored.
module i2c_cond_generator
  import i2c_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             bus_busy,
  input  logic             scl_in,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             done,
  output logic             cmd_err
);

  state_e           r_state;
  logic [DIV_W-1:0] r_div;
  logic             r_scl_oe;
  logic             r_sda_oe;
  logic             r_done;
  logic             r_cmd_err;

  cmd_e             w_cmd;
  state_e           w_first;
  state_e           w_next;
  logic             w_start_seq;
  logic             w_reject;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_load;
  logic [DIV_W-1:0] w_load_val;
  logic             w_en;
  logic             w_expire;

  assign w_cmd     = cmd_e'(cmd);
  assign w_div_eff = (clk_div == '0) ? DIV_W'(1) : clk_div;
  assign w_next    = next_phase(r_state);

  // Decode the first phase of a request; IDLE means the request is rejected
  always_comb begin
    w_first = IDLE;
    case (w_cmd)
      CMD_START:  w_first = bus_busy ? IDLE : ST_SDA_LO;
      CMD_RSTART: w_first = RS_SDA_HI;
      CMD_STOP:   w_first = SP_SDA_LO;
      default:    w_first = IDLE;
    endcase
    w_start_seq = (r_state == IDLE) && cmd_valid && (w_first != IDLE);
    w_reject    = (r_state == IDLE) && cmd_valid && (w_first == IDLE);
  end

  // Timer is reloaded on acceptance and on every phase change that stays busy
  always_comb begin
    w_load     = w_start_seq || (w_expire && (w_next != IDLE));
    w_load_val = w_start_seq ? w_div_eff : r_div;
`ifdef I2C_SCL_STRETCH_EN
    w_en = (r_state != IDLE) && !(is_scl_release(r_state) && !scl_in);
`else
    w_en = (r_state != IDLE);
`endif
  end

`ifndef I2C_SCL_STRETCH_EN
  logic w_unused_scl;
  assign w_unused_scl = scl_in;
`endif

  i2c_phase_timer #(
    .Width(DIV_W)
  ) u_phase_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_expire   (w_expire)
  );

  // Sequencer FSM with registered line enables and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_div     <= DIV_W'(1);
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      if (w_start_seq) begin
        r_state                <= w_first;
        r_div                  <= w_div_eff;
        {r_sda_oe, r_scl_oe}   <= phase_oe(w_first);
      end else if (w_reject) begin
        r_cmd_err <= 1'b1;
      end else if (w_expire) begin
        r_state <= w_next;
        if (w_next == IDLE) begin
          // Enables keep the final phase levels while idle
          r_done <= 1'b1;
        end else begin
          {r_sda_oe, r_scl_oe} <= phase_oe(w_next);
        end
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;
  assign done      = r_done;
  assign cmd_err   = r_cmd_err;

endmodule
